aes_sbox_scheduler: RTL and testbench
=====================================

// Module: aes_sbox_scheduler
// PURPOSE
//  Shares a bank of NUM_LANES S-box lanes between two requesters: the round datapath (SubBytes, 128-bit state)
//  and the key expansion (SubWord, 32-bit word). Time-multiplexes the 16 state bytes over 16/NUM_LANES beats.
//  Arbitrates simultaneous requests round-robin. Sits between the round controller, the key schedule and the S-box lanes.
// PARAMETERS
//  NUM_LANES  4   S-box lanes instantiated; legal values 4, 8, 16; BEATS = 16/NUM_LANES
// PORTS
//  clk           in   1    single clock, rising edge
//  rst           in   1    synchronous, active-high reset
//  st_req_valid  in   1    SubBytes request
//  st_req_ready  out  1    SubBytes request accepted when valid&ready
//  st_req_data   in   128  state; byte i = [8i+7:8i]
//  st_rsp_valid  out  1    one-cycle pulse, result valid
//  st_rsp_data   out  128  byte i = S(input byte i)
//  ks_req_valid  in   1    SubWord request
//  ks_req_ready  out  1    SubWord request accepted when valid&ready
//  ks_req_word   in   32   word; byte j = [8j+7:8j]
//  ks_rsp_valid  out  1    one-cycle pulse, result valid
//  ks_rsp_word   out  32   byte j = S(input byte j)
//  busy          out  1    FSM not in IDLE
// BEHAVIOUR
//  - Reset: FSM=IDLE, all *_rsp_valid=0, st_rsp_data=0, ks_rsp_word=0, busy=0, beat counter=0, last_grant=ST.
//  - FSM: IDLE -> ST_RUN (st accepted) | KS_RUN (ks accepted); ST_RUN -> IDLE after beat BEATS-1; KS_RUN -> IDLE after 1 beat.
//  - Readiness (IDLE only, else both 0): ks_req_ready = 1 unless st_req_valid && last_grant==KS;
//    st_req_ready = 1 unless ks_req_valid && last_grant==ST. At most one grant per cycle; last_grant updates on each grant.
//  - Request data captured into internal buffer at accept; requester may change inputs afterwards.
//  - ST_RUN beat k (k=0..BEATS-1, cycles T+1..T+BEATS, T = accept cycle): lanes process bytes k*NUM_LANES..+NUM_LANES-1;
//    results written into result buffer at end of cycle.
//  - KS_RUN: bytes 0..3 on lanes 0..3 in cycle T+1; lanes >=4 driven 8'h00, outputs ignored.
//  - Latency (no macro): st_rsp_valid at T+BEATS+1 (NUM_LANES=4 -> T+5); ks_rsp_valid at T+2.
//  - rsp_data/word hold the last result until the next rsp_valid; no back-pressure on responses.
//  - FSM returns to IDLE in the rsp_valid cycle; a new request may be accepted in that same cycle.
//  - Pending request not granted keeps waiting; no preemption of a running job.
//  - rst mid-operation: job dropped, no rsp pulse, state as reset.
// CONFIGURATION
//  SBOX_PIPE_EN defined: each lane output registered. One extra cycle per job (pipelined across beats):
//    st_rsp_valid at T+BEATS+2, ks_rsp_valid at T+3. FSM adds drain state before IDLE.
//  Undefined: lanes purely combinational; latencies as in BEHAVIOUR.
// STRUCTURE
//  aes_pkg: byte_t, word_t, block_t (128-bit), sched_state_e {IDLE, ST_RUN, KS_RUN, DRAIN}, grant_e {ST, KS},
//    SBOX_TABLE constant (256 x 8). Sub-module aes_sbox_lane (8-bit in -> 8-bit out lookup, optional output reg),
//    generate-instantiated NUM_LANES times.
// TESTING
//  1 ST 128'h0f0e0d0c0b0a09080706050403020100 -> st_rsp_data 128'h76abd7fe2b670130c56f6bf27b777c63 at T+5 (NUM_LANES=4).
//  2 KS 32'hcf4f3c09 -> ks_rsp_word 32'h8a84eb01 at T+2; ST all 8'h53 -> every byte 8'hED.
//  3 Both valid in IDLE after reset -> KS granted first, ST granted in KS rsp cycle; repeat tie -> alternates.
//  4 KS valid during ST_RUN -> ks_req_ready=0 until st_rsp_valid cycle, then granted; no ST beat disturbed.
//  5 rst at beat 2 of ST job -> no st_rsp_valid, outputs 0, next ST 128'hff.. -> all bytes 8'h16.
//  6 NUM_LANES 8/16 and SBOX_PIPE_EN: repeat 1-2, latency T+BEATS+1 / T+BEATS+2 exactly.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared types and the AES forward S-box table for the S-box scheduler slice.
// Build option SBOX_PIPE_EN (see aes_sbox_lane / aes_sbox_scheduler) does not affect this package.
package aes_pkg;

    typedef logic [7:0]   byte_t;
    typedef logic [31:0]  word_t;
    typedef logic [127:0] block_t;

    typedef enum logic [1:0] {IDLE, ST_RUN, KS_RUN, DRAIN} sched_state_e;
    typedef enum logic {ST, KS} grant_e;

    localparam byte_t SBOX_TABLE [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

endpackage

// File: rtl/aes_sbox_lane.sv
// One S-box lookup lane: 8-bit in, 8-bit out.
// With SBOX_PIPE_EN defined the output is registered (clk/rst ports exist only then).
module aes_sbox_lane
    import aes_pkg::*;
(
`ifdef SBOX_PIPE_EN
    input  logic       clk,
    input  logic       rst,
`endif
    input  logic [7:0] din,
    output logic [7:0] dout
);

`ifdef SBOX_PIPE_EN
    always_ff @(posedge clk) begin
        if (rst) dout <= '0;
        else     dout <= SBOX_TABLE[din];
    end
`else
    always_comb dout = SBOX_TABLE[din];
`endif

endmodule

// File: rtl/aes_sbox_scheduler.sv
// Round-robin scheduler sharing NUM_LANES S-box lanes between SubBytes (128-bit) and SubWord (32-bit).
// Define SBOX_PIPE_EN for registered lane outputs (one extra cycle per job, DRAIN state).
module aes_sbox_scheduler
    import aes_pkg::*;
#(
    parameter int NUM_LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         st_req_valid,
    output logic         st_req_ready,
    input  logic [127:0] st_req_data,
    output logic         st_rsp_valid,
    output logic [127:0] st_rsp_data,
    input  logic         ks_req_valid,
    output logic         ks_req_ready,
    input  logic [31:0]  ks_req_word,
    output logic         ks_rsp_valid,
    output logic [31:0]  ks_rsp_word,
    output logic         busy
);

    localparam int unsigned NL    = NUM_LANES;
    localparam int unsigned BEATS = 16 / NL;
    localparam int unsigned LW    = NL * 8;

    sched_state_e state;
    grant_e       last_grant;
    logic [3:0]   beat;
    block_t       st_buf;
    block_t       st_res;
    word_t        ks_buf;

    logic [7:0]    lane_in  [NL];
    logic [7:0]    lane_out [NL];
    logic [LW-1:0] lane_flat;
    block_t        st_merge;

    logic       st_fire, ks_fire;
    logic       wr_en, wr_ks, wr_last;
    logic [3:0] wr_beat;

    always_comb begin
        ks_req_ready = (state == IDLE) && !(st_req_valid && last_grant == KS);
        st_req_ready = (state == IDLE) && !(ks_req_valid && last_grant == ST);
        st_fire      = st_req_valid && st_req_ready;
        ks_fire      = ks_req_valid && ks_req_ready;
        busy         = (state != IDLE);
    end

    always_comb begin
        for (int unsigned l = 0; l < NL; l++) begin
            lane_in[l] = '0;
            if (state == ST_RUN)
                lane_in[l] = st_buf[(32'(beat) * NL + l) * 8 +: 8];
            else if (state == KS_RUN && l < 4)
                lane_in[l] = ks_buf[(l % 4) * 8 +: 8];
        end
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        aes_sbox_lane u_lane (
`ifdef SBOX_PIPE_EN
            .clk  (clk),
            .rst  (rst),
`endif
            .din  (lane_in[g]),
            .dout (lane_out[g])
        );
    end

    always_comb begin
        lane_flat = '0;
        for (int unsigned l = 0; l < NL; l++)
            lane_flat[l * 8 +: 8] = lane_out[l];
    end

    // Write-back qualifiers follow the lane outputs: same cycle, or one cycle later when lanes are registered.
`ifdef SBOX_PIPE_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en   <= 1'b0;
            wr_ks   <= 1'b0;
            wr_last <= 1'b0;
            wr_beat <= '0;
        end else begin
            wr_en   <= (state == ST_RUN) || (state == KS_RUN);
            wr_ks   <= (state == KS_RUN);
            wr_last <= (state == KS_RUN) || (state == ST_RUN && beat == 4'(BEATS - 1));
            wr_beat <= beat;
        end
    end
`else
    always_comb begin
        wr_en   = (state == ST_RUN) || (state == KS_RUN);
        wr_ks   = (state == KS_RUN);
        wr_last = (state == KS_RUN) || (state == ST_RUN && beat == 4'(BEATS - 1));
        wr_beat = beat;
    end
`endif

    always_comb begin
        st_merge = st_res;
        st_merge[32'(wr_beat) * LW +: LW] = lane_flat;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            last_grant   <= ST;
            beat         <= '0;
            st_buf       <= '0;
            ks_buf       <= '0;
            st_res       <= '0;
            st_rsp_valid <= 1'b0;
            ks_rsp_valid <= 1'b0;
            st_rsp_data  <= '0;
            ks_rsp_word  <= '0;
        end else begin
            st_rsp_valid <= 1'b0;
            ks_rsp_valid <= 1'b0;
            if (wr_en) begin
                if (wr_ks) begin
                    ks_rsp_word  <= lane_flat[31:0];
                    ks_rsp_valid <= 1'b1;
                end else begin
                    st_res <= st_merge;
                    if (wr_last) begin
                        st_rsp_data  <= st_merge;
                        st_rsp_valid <= 1'b1;
                    end
                end
            end
            case (state)
                IDLE: begin
                    beat <= '0;
                    if (st_fire) begin
                        st_buf     <= st_req_data;
                        last_grant <= ST;
                        state      <= ST_RUN;
                    end else if (ks_fire) begin
                        ks_buf     <= ks_req_word;
                        last_grant <= KS;
                        state      <= KS_RUN;
                    end
                end
                ST_RUN: begin
                    if (beat == 4'(BEATS - 1)) begin
                        beat <= '0;
`ifdef SBOX_PIPE_EN
                        state <= DRAIN;
`else
                        state <= IDLE;
`endif
                    end else begin
                        beat <= beat + 4'd1;
                    end
                end
                KS_RUN: begin
`ifdef SBOX_PIPE_EN
                    state <= DRAIN;
`else
                    state <= IDLE;
`endif
                end
                DRAIN:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_sbox_scheduler.sv
// Scoreboard bench for aes_sbox_scheduler; reference S-box derived from GF(2^8) inverse + affine map.
// Honours SBOX_PIPE_EN for expected latencies.
module tb_aes_sbox_scheduler;

    localparam int NL    = 4;
    localparam int BEATS = 16 / NL;
`ifdef SBOX_PIPE_EN
    localparam int LAT_ST = BEATS + 2;
    localparam int LAT_KS = 3;
`else
    localparam int LAT_ST = BEATS + 1;
    localparam int LAT_KS = 2;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         st_req_valid = 1'b0;
    logic         st_req_ready;
    logic [127:0] st_req_data = '0;
    logic         st_rsp_valid;
    logic [127:0] st_rsp_data;
    logic         ks_req_valid = 1'b0;
    logic         ks_req_ready;
    logic [31:0]  ks_req_word = '0;
    logic         ks_rsp_valid;
    logic [31:0]  ks_rsp_word;
    logic         busy;

    aes_sbox_scheduler #(.NUM_LANES(NL)) dut (
        .clk          (clk),
        .rst          (rst),
        .st_req_valid (st_req_valid),
        .st_req_ready (st_req_ready),
        .st_req_data  (st_req_data),
        .st_rsp_valid (st_rsp_valid),
        .st_rsp_data  (st_rsp_data),
        .ks_req_valid (ks_req_valid),
        .ks_req_ready (ks_req_ready),
        .ks_req_word  (ks_req_word),
        .ks_rsp_valid (ks_rsp_valid),
        .ks_rsp_word  (ks_rsp_word),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [127:0] d; int c; } exp_t;
    exp_t st_q[$];
    exp_t ks_q[$];

    int checks = 0;
    int failures = 0;

    logic [7:0] sbox_m [256];
    int  idle_from = 0;
    bit  last_ks = 1'b0;
    bit  acc_st, acc_ks;
    int  acc_cyc;
    bit  ov_st = 1'b0, ov_ks = 1'b0;
    logic [127:0] ov_st_val;
    logic [31:0]  ov_ks_val;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = '0;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    function automatic logic [127:0] sub_block(input logic [127:0] v);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[i*8 +: 8] = sbox_m[v[i*8 +: 8]];
        return r;
    endfunction

    // One cycle: check readiness/busy against the arbitration model, log accepts, advance past posedge.
    task automatic tick();
        bit idle, e_st, e_ks;
        exp_t e;
        @(negedge clk);
        idle = (cyc >= idle_from);
        e_ks = idle && !(st_req_valid && last_ks);
        e_st = idle && !(ks_req_valid && !last_ks);
        check("st_req_ready", 128'(st_req_ready), 128'(e_st));
        check("ks_req_ready", 128'(ks_req_ready), 128'(e_ks));
        check("busy", 128'(busy), 128'(!idle));
        acc_st  = st_req_valid && e_st;
        acc_ks  = ks_req_valid && e_ks;
        acc_cyc = cyc;
        if (acc_st) begin
            e.d = ov_st ? ov_st_val : sub_block(st_req_data);
            e.c = cyc + LAT_ST;
            st_q.push_back(e);
            idle_from = cyc + LAT_ST;
            last_ks = 1'b0;
            ov_st = 1'b0;
        end
        if (acc_ks) begin
            e.d = ov_ks ? 128'(ov_ks_val) : 128'(sub_block(128'(ks_req_word)) & 128'hffff_ffff);
            e.c = cyc + LAT_KS;
            ks_q.push_back(e);
            idle_from = cyc + LAT_KS;
            last_ks = 1'b1;
            ov_ks = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_st(input logic [127:0] d, output int c);
        bit done = 1'b0;
        st_req_valid = 1'b1;
        st_req_data  = d;
        c = -1;
        for (int i = 0; i < 64 && !done; i++) begin
            tick();
            if (acc_st) begin done = 1'b1; c = acc_cyc; end
        end
        if (!done) check("st_accept_timeout", 0, 1);
        st_req_valid = 1'b0;
        st_req_data  = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic send_ks(input logic [31:0] w, output int c);
        bit done = 1'b0;
        ks_req_valid = 1'b1;
        ks_req_word  = w;
        c = -1;
        for (int i = 0; i < 64 && !done; i++) begin
            tick();
            if (acc_ks) begin done = 1'b1; c = acc_cyc; end
        end
        if (!done) check("ks_accept_timeout", 0, 1);
        ks_req_valid = 1'b0;
        ks_req_word  = $urandom;
    endtask

    task automatic idle_ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle_from = 0;
        last_ks = 1'b0;
        st_q.delete();
        ks_q.delete();
    endtask

    // Response monitor: pops the scoreboard on every rsp pulse and checks hold behaviour otherwise.
    logic [127:0] st_hold = '0;
    logic [31:0]  ks_hold = '0;
    bit           rst_d = 1'b1;
    always @(negedge clk) begin
        exp_t e;
        if (rst_d) begin st_hold = '0; ks_hold = '0; end
        if (st_rsp_valid === 1'b1) begin
            if (st_q.size() == 0) check("st_rsp_unexpected", 1, 0);
            else begin
                e = st_q.pop_front();
                check("st_rsp_data", st_rsp_data, e.d);
                check("st_rsp_cycle", 128'(cyc), 128'(e.c));
            end
            st_hold = st_rsp_data;
        end else if (!rst_d) begin
            check("st_rsp_hold", st_rsp_data, st_hold);
        end
        if (ks_rsp_valid === 1'b1) begin
            if (ks_q.size() == 0) check("ks_rsp_unexpected", 1, 0);
            else begin
                e = ks_q.pop_front();
                check("ks_rsp_word", 128'(ks_rsp_word), e.d);
                check("ks_rsp_cycle", 128'(cyc), 128'(e.c));
            end
            ks_hold = ks_rsp_word;
        end else if (!rst_d) begin
            check("ks_rsp_hold", 128'(ks_rsp_word), 128'(ks_hold));
        end
        rst_d = rst;
    end

    initial begin
        int c1, c2, k;
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_m[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end

        @(posedge clk);
        #1;
        idle_ticks(3);
        rst = 1'b0;
        check("reset_st_rsp_valid", 128'(st_rsp_valid), 0);
        check("reset_ks_rsp_valid", 128'(ks_rsp_valid), 0);
        check("reset_st_rsp_data", st_rsp_data, 0);
        check("reset_ks_rsp_word", 128'(ks_rsp_word), 0);
        check("reset_busy", 128'(busy), 0);

        // Simultaneous requests right after reset: KS first, ST in the KS response cycle.
        st_req_valid = 1'b1; st_req_data = {16{8'h5a}};
        ks_req_valid = 1'b1; ks_req_word = 32'h01234567;
        tick();
        check("tie_ks_granted", 128'(acc_ks), 1);
        check("tie_st_waits", 128'(acc_st), 0);
        c1 = acc_cyc;
        ks_req_valid = 1'b0;
        send_st({16{8'h5a}}, c2);
        check("tie_st_grant_cycle", 128'(c2), 128'(c1 + LAT_KS));
        idle_ticks(LAT_ST);

        ov_st = 1'b1; ov_st_val = 128'h76abd7fe2b670130c56f6bf27b777c63;
        send_st(128'h0f0e0d0c0b0a09080706050403020100, c1);
        idle_ticks(LAT_ST);
        ov_ks = 1'b1; ov_ks_val = 32'h8a84eb01;
        send_ks(32'hcf4f3c09, c1);
        idle_ticks(LAT_KS);
        ov_st = 1'b1; ov_st_val = {16{8'hed}};
        send_st({16{8'h53}}, c1);
        idle_ticks(LAT_ST);

        // KS arriving while ST runs waits for the ST response cycle.
        send_st({$urandom, $urandom, $urandom, $urandom}, c1);
        ks_req_valid = 1'b1; ks_req_word = $urandom;
        c2 = -1;
        for (int i = 0; i < 64 && c2 < 0; i++) begin
            tick();
            if (acc_ks) c2 = acc_cyc;
        end
        ks_req_valid = 1'b0;
        check("ks_after_st_cycle", 128'(c2), 128'(c1 + LAT_ST));
        idle_ticks(LAT_KS);

        // Reset in the middle of an ST job drops it.
        send_st({$urandom, $urandom, $urandom, $urandom}, c1);
        k = (BEATS - 1 < 2) ? BEATS - 1 : 2;
        idle_ticks(k);
        do_reset();
        check("midrst_st_rsp_valid", 128'(st_rsp_valid), 0);
        check("midrst_st_rsp_data", st_rsp_data, 0);
        check("midrst_ks_rsp_word", 128'(ks_rsp_word), 0);
        check("midrst_busy", 128'(busy), 0);
        idle_ticks(LAT_ST + 1);
        ov_st = 1'b1; ov_st_val = {16{8'h16}};
        send_st({16{8'hff}}, c1);
        idle_ticks(LAT_ST);

        for (int i = 0; i < 800; i++) begin
            if (!st_req_valid && $urandom_range(0, 3) == 0) begin
                st_req_valid = 1'b1;
                if ($urandom_range(0, 7) == 0) st_req_data = {16{8'($urandom)}};
                else st_req_data = {$urandom, $urandom, $urandom, $urandom};
            end
            if (!ks_req_valid && $urandom_range(0, 2) == 0) begin
                ks_req_valid = 1'b1;
                ks_req_word  = $urandom;
            end
            tick();
            if (acc_st) begin
                st_req_valid = 1'b0;
                st_req_data  = {$urandom, $urandom, $urandom, $urandom};
            end
            if (acc_ks) begin
                ks_req_valid = 1'b0;
                ks_req_word  = $urandom;
            end
        end
        st_req_valid = 1'b0;
        ks_req_valid = 1'b0;

        for (int i = 0; i < 100 && (st_q.size() != 0 || ks_q.size() != 0); i++) tick();
        tick();
        check("drain_st_queue", 128'(st_q.size()), 0);
        check("drain_ks_queue", 128'(ks_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
